// File: rtl/sqr32_check.sv
// Shift-add squarer that checks a candidate root y against a radicand x.
// It reports sq = y*y, rem = x - sq, and whether y is exactly floor(sqrt(x)).
module sqr32_check #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [W-1:0]   y,
  input  logic [2*W-1:0] x,
  output logic           busy,
  output logic           done,
  output logic [2*W-1:0] sq,
  output logic [2*W-1:0] rem,
  output logic           too_big,
  output logic           too_small,
  output logic           ok
);

  localparam int CW = (W > 1) ? $clog2(W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, CHK} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   y_q, y_d;
  logic [2*W-1:0] x_q, x_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*W-1:0] sq_q, sq_d;
  logic [2*W-1:0] rem_q, rem_d;
  logic           too_big_q, too_big_d;
  logic           too_small_q, too_small_d;
  logic           ok_q, ok_d;
  logic           done_q, done_d;

  logic [2*W-1:0] diff;
  logic [2*W-1:0] two_y;
  logic [2*W-1:0] pp;
  logic           over;

  // (y+1)^2 <= x is tested as x - y^2 > 2y so nothing ever needs more than 2W bits.
  assign diff  = x_q - acc_q;
  assign two_y = {{(W-1){1'b0}}, y_q, 1'b0};
  assign over  = (acc_q > x_q);
  assign pp    = y_q[cnt_q] ? {{W{1'b0}}, y_q} : '0;

  always_comb begin
    state_d     = state_q;
    y_d         = y_q;
    x_d         = x_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sq_d        = sq_q;
    rem_d       = rem_q;
    too_big_d   = too_big_q;
    too_small_d = too_small_q;
    ok_d        = ok_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          y_d     = y;
          x_d     = x;
          acc_d   = '0;
          cnt_d   = CW'(W - 1);
        end
      end
      RUN: begin
        // MSB-first: double the running sum, then add y when this root bit is set.
        acc_d = {acc_q[2*W-2:0], 1'b0} + pp;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d = CHK;
        end
      end
      CHK: begin
        state_d     = IDLE;
        sq_d        = acc_q;
        rem_d       = diff;
        too_big_d   = over;
        too_small_d = !over && (diff > two_y);
        ok_d        = !over && !(diff > two_y);
        done_d      = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      y_q         <= '0;
      x_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      sq_q        <= '0;
      rem_q       <= '0;
      too_big_q   <= 1'b0;
      too_small_q <= 1'b0;
      ok_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      y_q         <= y_d;
      x_q         <= x_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      sq_q        <= sq_d;
      rem_q       <= rem_d;
      too_big_q   <= too_big_d;
      too_small_q <= too_small_d;
      ok_q        <= ok_d;
      done_q      <= done_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sq        = sq_q;
  assign rem       = rem_q;
  assign too_big   = too_big_q;
  assign too_small = too_small_q;
  assign ok        = ok_q;

endmodule

// File: tb/tb_sqr32_check.sv
// Directed and random checks for sqr32_check: latency, results, flags,
// ignored start while busy, back-to-back start, and reset abort.
module tb_sqr32_check;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] y;
  logic [31:0] x;
  logic        busy;
  logic        done;
  logic [31:0] sq;
  logic [31:0] rem;
  logic        too_big;
  logic        too_small;
  logic        ok;

  int n_checks = 0;
  int n_fail   = 0;

  sqr32_check #(.W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .y         (y),
    .x         (x),
    .busy      (busy),
    .done      (done),
    .sq        (sq),
    .rem       (rem),
    .too_big   (too_big),
    .too_small (too_small),
    .ok        (ok)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [31:0] esq, input logic [31:0] erem,
                           input logic etb, input logic ets, input logic eok);
    check({tag, "_sq"}, 64'(sq), 64'(esq));
    if (!etb) check({tag, "_rem"}, 64'(rem), 64'(erem));
    check({tag, "_too_big"}, 64'(too_big), 64'(etb));
    check({tag, "_too_small"}, 64'(too_small), 64'(ets));
    check({tag, "_ok"}, 64'(ok), 64'(eok));
  endtask

  // Drive a request; returns #1 after the accepting edge E0.
  task automatic launch(input logic [15:0] yv, input logic [31:0] xv);
    start = 1'b1;
    y     = yv;
    x     = xv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges since E0 until done is seen, bounded.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!done && lat < 40);
  endtask

  task automatic op(input string tag, input logic [15:0] yv, input logic [31:0] xv,
                    input logic [31:0] esq, input logic [31:0] erem,
                    input logic etb, input logic ets, input logic eok);
    int lat;
    launch(yv, xv);
    wait_done(0, lat);
    check({tag, "_latency"}, 64'(lat), 64'd17);
    check_res(tag, esq, erem, etb, ets, eok);
    $display("op %s: y=%0d x=%0d sq=%0d rem=%0d tb=%0b ts=%0b ok=%0b lat=%0d",
             tag, yv, xv, sq, rem, too_big, too_small, ok, lat);
  endtask

  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] r;
    logic [15:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (16'd1 << b);
      if ({32'd0, t} * {32'd0, t} <= {32'd0, v}) r = t;
    end
    return r;
  endfunction

  initial begin
    int          lat;
    logic        seen_done;
    logic [31:0] rx;
    logic [15:0] ry;
    logic [31:0] rsq;

    reset = 1'b0;
    start = 1'b0;
    y     = '0;
    x     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check_res("rst", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    op("t1", 16'd3, 32'd10, 32'd9, 32'd1, 1'b0, 1'b0, 1'b1);
    op("t2", 16'hFFFF, 32'hFFFFFFFF, 32'hFFFE0001, 32'h0001FFFE, 1'b0, 1'b0, 1'b1);
    op("t3a", 16'd5, 32'd24, 32'd25, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    op("t3b", 16'd4, 32'd25, 32'd16, 32'd9, 1'b0, 1'b1, 1'b0);
    op("t4a", 16'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    op("t4b", 16'd0, 32'd1, 32'd0, 32'd1, 1'b0, 1'b1, 1'b0);
    op("t4c", 16'd10, 32'd120, 32'd100, 32'd20, 1'b0, 1'b0, 1'b1);

    // Start while busy must be ignored.
    launch(16'd7, 32'd49);
    check("t5_busy", 64'(busy), 64'd1);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    y     = 16'd2;
    x     = 32'd4;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(5, lat);
    check("t5a_latency", 64'(lat), 64'd17);
    check("t5a_busy_in_done", 64'(busy), 64'd0);
    check_res("t5a", 32'd49, 32'd0, 1'b0, 1'b0, 1'b1);
    $display("op t5a: sq=%0d ok=%0b lat=%0d", sq, ok, lat);
    // Back-to-back start in the done cycle.
    launch(16'd2, 32'd4);
    check("t5b_busy", 64'(busy), 64'd1);
    wait_done(0, lat);
    check("t5b_latency", 64'(lat), 64'd17);
    check_res("t5b", 32'd4, 32'd0, 1'b0, 1'b0, 1'b1);
    $display("op t5b: sq=%0d ok=%0b lat=%0d", sq, ok, lat);

    // Reset abort mid-operation.
    launch(16'd9, 32'd81);
    repeat (7) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("t6_busy", 64'(busy), 64'd0);
    check("t6_done", 64'(done), 64'd0);
    check("t6_sq", 64'(sq), 64'd0);
    seen_done = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done) seen_done = 1'b1;
    end
    check("t6_no_done", 64'(seen_done), 64'd0);
    $display("op t6: reset abort, done seen=%0b", seen_done);
    reset = 1'b1;
    @(negedge clk);
    op("t6r", 16'd9, 32'd81, 32'd81, 32'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 200; i++) begin
      rx  = $urandom;
      if (i == 0) rx = 32'hFFFE0001;
      ry  = isqrt(rx);
      rsq = 32'(ry) * 32'(ry);
      op("rnd_exact", ry, rx, rsq, rx - rsq, 1'b0, 1'b0, 1'b1);
      if (ry != 16'hFFFF) begin
        rsq = 32'(ry + 16'd1) * 32'(ry + 16'd1);
        op("rnd_plus1", ry + 16'd1, rx, rsq, rx - rsq, 1'b1, 1'b0, 1'b0);
      end else begin
        rsq = 32'(ry - 16'd1) * 32'(ry - 16'd1);
        op("rnd_minus1", ry - 16'd1, rx, rsq, rx - rsq, 1'b0, 1'b1, 1'b0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
